// File: rtl/core_mem_pkg.sv
// Shared definitions for the unified memory port.
// Owner encoding, width defaults and latency bounds.
package core_mem_pkg;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Latency-matched {live, owner} tag shift register.
// Flush kills every fetch-owned entry, incoming one included.
module arb_tag_pipe
  import core_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_live,
  input  logic push_owner,
  input  logic flush,
  output logic tail_live,
  output logic tail_owner
);

  logic [DEPTH-1:0] live_q;
  logic [DEPTH-1:0] own_q;
  logic [DEPTH-1:0] live_d;
  logic [DEPTH-1:0] own_d;

  // Next state: shift by one, dropping fetch entries on flush
  always_comb begin
    live_d = live_q;
    own_d  = own_q;
    live_d[0] = push_live & ~(flush & (push_owner == OWN_IF));
    own_d[0]  = push_owner;
    for (int i = 1; i < DEPTH; i++) begin
      live_d[i] = live_q[i-1] & ~(flush & (own_q[i-1] == OWN_IF));
      own_d[i]  = own_q[i-1];
    end
  end

  // Tag storage; reset drops everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= '0;
      own_q  <= '0;
    end else begin
      live_q <= live_d;
      own_q  <= own_d;
    end
  end

  assign tail_live  = live_q[DEPTH-1];
  assign tail_owner = own_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / memory-stage arbiter for the single RAM port.
// Grants, burst limiting, port mux and read return routing.
module mem_port_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MEM_LAT       = 1,
  parameter int MAX_MEM_BURST = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_lock,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be 1..4");
  end

  localparam int CNT_W = $clog2(MAX_MEM_BURST + 1);

  logic [CNT_W-1:0] burst_cnt;
  logic             burst_full;
  logic             if_win;
  logic             mem_win;
  logic             push_live;
  logic             push_owner;
  logic             tail_live;
  logic             tail_owner;

  assign burst_full = (burst_cnt == CNT_W'(MAX_MEM_BURST));

  // Winner select: MEM first, fetch forced in after a full burst
  always_comb begin
    if_win  = 1'b0;
    mem_win = 1'b0;
    if (!rst) begin
      if (mem_req && if_req) begin
        if (burst_full && !mem_lock) if_win = 1'b1;
        else mem_win = 1'b1;
      end else if (mem_req) begin
        mem_win = 1'b1;
      end else if (if_req && !mem_lock) begin
        if_win = 1'b1;
      end
    end
  end

  assign if_gnt  = if_win;
  assign mem_gnt = mem_win;

  // Count MEM grants that starve a waiting fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (mem_win && if_req) begin
      if (!burst_full) burst_cnt <= burst_cnt + 1'b1;
    end else if (if_win || !mem_win) begin
      burst_cnt <= '0;
    end
  end

  // RAM port follows the winner; idle port is driven to 0
  always_comb begin
    ram_en    = if_win | mem_win;
    ram_we    = mem_win & mem_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (mem_win) begin
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end else if (if_win) begin
      ram_addr  = if_addr;
    end
  end

  assign push_live  = if_win | (mem_win & ~mem_we);
  assign push_owner = mem_win ? OWN_MEM : OWN_IF;

  arb_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .push_live  (push_live),
    .push_owner (push_owner),
    .flush      (if_flush),
    .tail_live  (tail_live),
    .tail_owner (tail_owner)
  );

  // Route returning read data to the owner of the tail tag
  always_comb begin
    if_valid  = tail_live & (tail_owner == OWN_IF);
    mem_valid = tail_live & (tail_owner == OWN_MEM);
    if_rdata  = if_valid  ? ram_rdata : '0;
    mem_rdata = mem_valid ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Reference model: grant rules, cycle-stamped read returns.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       if_req = 1'b0;
  logic [7:0] if_addr = '0;
  logic       if_flush = 1'b0;
  logic       if_gnt, if_valid;
  logic [7:0] if_rdata;
  logic       mem_req = 1'b0;
  logic       mem_we = 1'b0;
  logic       mem_lock = 1'b0;
  logic [7:0] mem_addr = '0;
  logic [7:0] mem_wdata = '0;
  logic       mem_gnt, mem_valid;
  logic [7:0] mem_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  mem_port_arbiter #(
    .ADDR_W (8), .DATA_W (8),
    .MEM_LAT (LAT), .MAX_MEM_BURST (MAXB)
  ) dut (
    .clk (clk), .rst (rst),
    .if_req (if_req), .if_addr (if_addr),
    .if_flush (if_flush), .if_gnt (if_gnt),
    .if_valid (if_valid), .if_rdata (if_rdata),
    .mem_req (mem_req), .mem_we (mem_we),
    .mem_lock (mem_lock), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_gnt (mem_gnt),
    .mem_valid (mem_valid), .mem_rdata (mem_rdata),
    .ram_en (ram_en), .ram_we (ram_we),
    .ram_addr (ram_addr), .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM with LAT-cycle read pipeline; junk when idle
  logic [7:0] ram [256];
  logic [7:0] rd_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr] : 8'($urandom);
    if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = rd_pipe[LAT-1];

  typedef struct {
    bit         own;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [256];
  int         burst = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string nm, input bit ok,
                     input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Drive one cycle, check grants/port against the model, queue reads
  task automatic step(input logic ir, input logic [7:0] ia,
                      input logic fl, input logic mr,
                      input logic we, input logic lk,
                      input logic [7:0] ma, input logic [7:0] wd,
                      output logic eg_i, output logic eg_m,
                      output logic dg_i);
    logic ig, mg;
    logic [7:0] a;
    exp_t keep[$];
    @(negedge clk);
    if_req = ir; if_addr = ia; if_flush = fl;
    mem_req = mr; mem_we = we; mem_lock = lk;
    mem_addr = ma; mem_wdata = wd;
    #3;
    ig = 1'b0; mg = 1'b0;
    if (mr && ir) begin
      if (burst == MAXB && !lk) ig = 1'b1;
      else mg = 1'b1;
    end else if (mr) mg = 1'b1;
    else if (ir && !lk) ig = 1'b1;
    chk("if_gnt", if_gnt == ig, if_gnt, ig);
    chk("mem_gnt", mem_gnt == mg, mem_gnt, mg);
    chk("ram_en", ram_en == (ig | mg), ram_en, ig | mg);
    a = mg ? ma : ia;
    if (ig || mg) begin
      chk("ram_we", ram_we == (mg & we), ram_we, mg & we);
      chk("ram_addr", ram_addr == a, ram_addr, a);
      chk("ram_wdata", ram_wdata == (mg ? wd : 8'h00),
          ram_wdata, mg ? wd : 8'h00);
    end
    if (ig || (mg && !we))
      sb.push_back('{own: mg, data: ref_mem[a], due: cyc + LAT});
    if (fl) begin
      foreach (sb[i])
        if (sb[i].own || sb[i].due <= cyc) keep.push_back(sb[i]);
      sb = keep;
    end
    if (mg && we) ref_mem[ma] = wd;
    if (mg && ir) burst = (burst < MAXB) ? burst + 1 : MAXB;
    else if (ig || !mg) burst = 0;
    eg_i = ig; eg_m = mg; dg_i = if_gnt;
  endtask

  // Reset pulse with requests held; all outputs must stay 0
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
    if_addr = 8'h44; mem_addr = 8'h55;
    sb.delete();
    burst = 0;
    repeat (2) begin
      #3;
      chk("reset_outs",
          {if_gnt, if_valid, if_rdata, mem_gnt, mem_valid,
           mem_rdata, ram_en, ram_we, ram_addr, ram_wdata} == '0,
          {if_gnt, if_valid, mem_gnt, mem_valid, ram_en, ram_we}, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_flush = 1'b0; mem_lock = 1'b0;
  endtask

  // Monitor: pop expected returns whenever the DUT presents one
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("valid_excl", !(if_valid && mem_valid),
            {if_valid, mem_valid}, 0);
        if (!if_valid)
          chk("if_rdata_idle", if_rdata == 0, if_rdata, 0);
        if (!mem_valid)
          chk("mem_rdata_idle", mem_rdata == 0, mem_rdata, 0);
        if (if_valid || mem_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", 1'b0, {if_valid, mem_valid}, 0);
          end else begin
            e = sb.pop_front();
            chk("ret_owner", mem_valid == e.own, mem_valid, e.own);
            chk("ret_data",
                (mem_valid ? mem_rdata : if_rdata) == e.data,
                mem_valid ? mem_rdata : if_rdata, e.data);
            chk("ret_cycle", cyc == e.due, cyc, e.due);
          end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("missing_valid", 1'b0, 0, e.due);
        end
      end
    end
  end

  initial begin
    logic gi, gm, di;
    logic pi, pm, pwe;
    logic [7:0] pia, pma, pwd;
    logic exp_seq [5];
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;

    do_reset();

    // Single fetch read of 0x10 (0xA5 expected back at T+2)
    step(1, 8'h10, 0, 0, 0, 0, 0, 0, gi, gm, di);
    chk("t1_gnt_addr", di && ram_addr == 8'h10, ram_addr, 8'h10);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, gi, gm, di);

    // Simultaneous fetch and MEM read: MEM first, then fetch
    step(1, 8'h11, 0, 1, 0, 0, 8'h20, 0, gi, gm, di);
    chk("t2_mem_first", mem_gnt && !di, {di, mem_gnt}, 1);
    step(1, 8'h11, 0, 0, 0, 0, 0, 0, gi, gm, di);
    chk("t2_if_second", di, di, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, gi, gm, di);

    // Burst limit: M,M,M,I,M
    for (int k = 0; k < 5; k++) begin
      step(1, 8'h12, 0, 1, 0, 0, 8'(8'h40 + k), 0, gi, gm, di);
      chk("burst_seq", di == exp_seq[k], di, exp_seq[k]);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, gi, gm, di);

    // Locked: fetch never wins
    for (int k = 0; k < 5; k++) begin
      step(1, 8'h13, 0, 1, 0, 1, 8'(8'h50 + k), 0, gi, gm, di);
      chk("lock_no_if", di == 1'b0, di, 0);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, gi, gm, di);

    // Fetch read then flush next cycle alongside a MEM write
    step(1, 8'h14, 0, 0, 0, 0, 0, 0, gi, gm, di);
    step(0, 0, 1, 1, 1, 0, 8'h30, 8'h5A, gi, gm, di);
    chk("flush_wr_port", ram_we && ram_wdata == 8'h5A &&
        ram_addr == 8'h30, ram_wdata, 8'h5A);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, gi, gm, di);

    // Reset with two reads in flight, then burst restarts from 0
    step(1, 8'h15, 0, 0, 0, 0, 0, 0, gi, gm, di);
    step(0, 0, 0, 1, 0, 0, 8'h60, 0, gi, gm, di);
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, gi, gm, di);
    for (int k = 0; k < 5; k++) begin
      step(1, 8'h16, 0, 1, 0, 0, 8'(8'h70 + k), 0, gi, gm, di);
      chk("rst_burst_seq", di == exp_seq[k], di, exp_seq[k]);
    end

    // Randomized traffic with requesters holding until granted
    pi = 0; pm = 0; pwe = 0; pia = 0; pma = 0; pwd = 0;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset();
        pi = 0; pm = 0;
      end
      if (!pi && $urandom_range(0, 2) != 0) begin
        pi = 1; pia = 8'($urandom);
      end
      if (!pm && $urandom_range(0, 2) != 0) begin
        pm = 1; pwe = 1'($urandom);
        pma = 8'($urandom); pwd = 8'($urandom);
      end
      step(pi, pia, $urandom_range(0, 9) == 0, pm, pwe,
           $urandom_range(0, 7) == 0, pma, pwd, gi, gm, di);
      if (gi) pi = 0;
      if (gm) pm = 0;
    end

    repeat (LAT + 3) step(0, 0, 0, 0, 0, 0, 0, 0, gi, gm, di);
    chk("sb_drained", sb.size() == 0, sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory between the fetch stage and the memory stage of the pipelined core. Each cycle it grants at most one access, drives the physical RAM port, and tracks in-flight reads through a latency-matched tag pipeline so returning data reaches the correct requester. Stack pushes/pops, the interrupt PC-save/vector sequence, and LDD/STD/LDI/STI traffic all pass through it. Its grant signals feed the fetch stall logic (PC_Write_En / IF_ID_Write_En).

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 1, cycles from `ram_en` to valid `ram_rdata`; legal range 1..4
- MAX_MEM_BURST, 3, consecutive MEM grants allowed before a pending fetch is forced through
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request, level; held until `if_gnt`
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  discard every in-flight fetch read (taken branch, interrupt)
- if_gnt  out  1  fetch request accepted this cycle
- if_valid  out  1  fetch read data valid, one-cycle pulse
- if_rdata  out  DATA_W  fetch read data
- mem_req  in  1  memory-stage request, level; held until `mem_gnt`
- mem_we  in  1  1 = write, 0 = read
- mem_lock  in  1  holds the port for MEM (interrupt push + vector read, CALL push)
- mem_addr  in  ADDR_W  data/stack address
- mem_wdata  in  DATA_W  write data
- mem_gnt  out  1  memory request accepted this cycle
- mem_valid  out  1  memory read data valid, one-cycle pulse (reads only)
- mem_rdata  out  DATA_W  memory read data
- ram_en, ram_we  out  1  RAM port enable / write
- ram_addr  out  ADDR_W, ram_wdata  out  DATA_W  RAM port address / write data
- ram_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after `ram_en` with `!ram_we`

## Operation
- Grant rule, evaluated combinationally each cycle:
  - `mem_req` only → MEM.
  - `if_req` only → IF.
  - Both asserted → MEM, unless `burst_cnt == MAX_MEM_BURST` and `!mem_lock`, in which case IF.
  - `mem_lock` high → IF is never granted, even when MEM is idle.
- `burst_cnt`:
  - +1 on a MEM grant while `if_req` is asserted.
  - Cleared on an IF grant, or on any cycle with no MEM grant.
  - Saturates at MAX_MEM_BURST.
- RAM port mirrors the granted requester: `ram_en = if_gnt | mem_gnt`; `ram_we = mem_gnt & mem_we`; `ram_addr` and `ram_wdata` are muxed from the winner. `ram_wdata` is 0 when the winner is IF.
- Tag pipeline: MEM_LAT-deep shift register of {live, owner}. A read grant pushes {1, owner}; a write or idle cycle pushes {0, x}.
- At the tail of the tag pipeline:
  - live & owner = IF → `if_valid = 1`, `if_rdata = ram_rdata`.
  - live & owner = MEM → `mem_valid = 1`, `mem_rdata = ram_rdata`.
  - Otherwise both valids are 0 and both rdata outputs are 0.
- Writes complete at grant; they produce no `mem_valid`.
- `if_flush` clears `live` on every IF-owned entry, including one granted in the same cycle. MEM entries are unaffected.
- `mem_lock` never blocks MEM and never revokes an already-issued IF read.
- Reset (async, any time): tag pipeline cleared, `burst_cnt = 0`, every output 0. In-flight reads are dropped and never return a valid.

## Timing
- Grant latency: 0 cycles; `*_gnt` is asserted in the same cycle as the winning `*_req`.
- Read latency: grant in cycle T → `*_valid` in cycle T+MEM_LAT. Reads are fully pipelined, one per cycle.
- Requesters may present a new request in the cycle after their grant.
- Outputs are combinational from registered tags plus `ram_rdata`. There is no registered output stage.
- Back-to-back alternating IF/MEM reads return in issue order, one per cycle.

## Structure
- Shared package `core_mem_pkg` holds:
  - the owner encoding (`OWN_IF = 1'b0`, `OWN_MEM = 1'b1`);
  - defaults for ADDR_W and DATA_W;
  - the MEM_LAT range check.
- Sub-module `arb_tag_pipe` holds the parameterized {live, owner} shift register with flush-by-owner.
- The top level holds the grant logic, `burst_cnt`, and the port mux.

## Test plan
- Reset then release, MEM_LAT=2: `if_req`, `if_addr=0x10` → `if_gnt` and `ram_addr=0x10` in cycle T; RAM returns 0xA5 → `if_valid=1`, `if_rdata=0xA5` at T+2; all outputs 0 during reset.
- Simultaneous `if_req` (0x11) and `mem_req` read (0x20) → cycle T grants MEM, cycle T+1 grants IF; `mem_valid` at T+2, `if_valid` at T+3.
- `if_req` held with `mem_req` for 5 cycles, MAX_MEM_BURST=3 → grant sequence M,M,M,I,M.
- Same stimulus with `mem_lock=1` → five MEM grants, `if_gnt` stays 0.
- IF read granted at T, `if_flush` at T+1, MEM_LAT=2 → no `if_valid` at T+2. A MEM write to 0x30 of 0x5A issued at T+1 → `ram_we=1`, `ram_wdata=0x5A`, no `mem_valid`.
- `rst` pulsed while two reads are in flight → no `if_valid`/`mem_valid` after release; `burst_cnt` restarts from 0.
